// File: rtl/lc3_mem_responder.sv
// Unified word-addressed memory answering LC3 instruction fetches and data accesses
// after a programmable latency. Optional macro LC3_MEM_RAND_STALL_EN adds 0..7 random wait cycles.
module lc3_mem_responder #(
    parameter int AW        = 16,
    parameter int INSTR_LAT = 1,
    parameter int DATA_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instrmem_rd,
    input  logic [15:0] pc,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        data_req,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [15:0] mem_r [DEPTH];

    logic [AW-1:0] pc_s;
    logic [AW-1:0] da_s;
    logic [AW-1:0] la_s;
    logic [8:0]    i_lat_s;
    logic [8:0]    d_lat_s;

    state_t        i_state_r, i_state_s;
    logic [8:0]    i_cnt_r, i_cnt_s;
    logic [AW-1:0] i_addr_r, i_addr_s;
    logic [15:0]   i_dout_r, i_dout_s;
    logic          i_cmp_r, i_cmp_s;

    state_t        d_state_r, d_state_s;
    logic [8:0]    d_cnt_r, d_cnt_s;
    logic [AW-1:0] d_addr_r, d_addr_s;
    logic          d_rd_r, d_rd_s;
    logic [15:0]   d_din_r, d_din_s;
    logic [15:0]   d_dout_r, d_dout_s;
    logic          d_cmp_r, d_cmp_s;
    logic          d_chg_s;
    logic          d_we_s;
    logic [AW-1:0] d_waddr_s;
    logic [15:0]   d_wdata_s;

    assign pc_s = pc[AW-1:0];
    assign da_s = Data_addr[AW-1:0];
    assign la_s = load_addr[AW-1:0];

`ifdef LC3_MEM_RAND_STALL_EN
    logic [15:0] lfsr_r;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Free-running stall generator.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign i_lat_s = 9'(INSTR_LAT) + {6'd0, lfsr_r[2:0]};
    assign d_lat_s = 9'(DATA_LAT) + {6'd0, lfsr_r[5:3]};
`else
    assign i_lat_s = 9'(INSTR_LAT);
    assign d_lat_s = 9'(DATA_LAT);
`endif

    // Instruction FSM next state; a changed pc re-accepts just like a fresh request.
    always_comb begin
        i_state_s = i_state_r;
        i_cnt_s   = i_cnt_r;
        i_addr_s  = i_addr_r;
        i_dout_s  = i_dout_r;
        i_cmp_s   = 1'b0;
        if (!instrmem_rd) begin
            i_state_s = ST_IDLE;
        end else if (i_state_r == ST_IDLE || pc_s != i_addr_r) begin
            i_addr_s = pc_s;
            if (i_lat_s == 9'd1) begin
                i_state_s = ST_DONE;
                i_cnt_s   = 9'd0;
                i_dout_s  = mem_r[pc_s];
                i_cmp_s   = 1'b1;
            end else begin
                i_state_s = ST_WAIT;
                i_cnt_s   = i_lat_s - 9'd1;
            end
        end else begin
            case (i_state_r)
                ST_WAIT: begin
                    if (i_cnt_r <= 9'd1) begin
                        i_state_s = ST_DONE;
                        i_cnt_s   = 9'd0;
                        i_dout_s  = mem_r[i_addr_r];
                        i_cmp_s   = 1'b1;
                    end else begin
                        i_cnt_s = i_cnt_r - 9'd1;
                    end
                end
                ST_DONE: i_cmp_s = 1'b1;
                default: i_state_s = ST_IDLE;
            endcase
        end
    end

    // Instruction FSM registers and outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_state_r <= ST_IDLE;
            i_cnt_r   <= 9'd0;
            i_addr_r  <= '0;
            i_dout_r  <= 16'h0000;
            i_cmp_r   <= 1'b0;
        end else begin
            i_state_r <= i_state_s;
            i_cnt_r   <= i_cnt_s;
            i_addr_r  <= i_addr_s;
            i_dout_r  <= i_dout_s;
            i_cmp_r   <= i_cmp_s;
        end
    end

    assign d_chg_s = (da_s != d_addr_r) || (Data_rd != d_rd_r);

    // Data FSM next state; a write is issued only on the edge entering DONE.
    always_comb begin
        d_state_s = d_state_r;
        d_cnt_s   = d_cnt_r;
        d_addr_s  = d_addr_r;
        d_rd_s    = d_rd_r;
        d_din_s   = d_din_r;
        d_dout_s  = d_dout_r;
        d_cmp_s   = 1'b0;
        d_we_s    = 1'b0;
        d_waddr_s = d_addr_r;
        d_wdata_s = d_din_r;
        if (!data_req) begin
            d_state_s = ST_IDLE;
        end else if (d_state_r == ST_IDLE || d_chg_s) begin
            d_addr_s = da_s;
            d_rd_s   = Data_rd;
            d_din_s  = Data_din;
            if (d_lat_s == 9'd1) begin
                d_state_s = ST_DONE;
                d_cnt_s   = 9'd0;
                d_cmp_s   = 1'b1;
                if (Data_rd) begin
                    d_dout_s = mem_r[da_s];
                end else begin
                    d_we_s    = 1'b1;
                    d_waddr_s = da_s;
                    d_wdata_s = Data_din;
                end
            end else begin
                d_state_s = ST_WAIT;
                d_cnt_s   = d_lat_s - 9'd1;
            end
        end else begin
            case (d_state_r)
                ST_WAIT: begin
                    if (d_cnt_r <= 9'd1) begin
                        d_state_s = ST_DONE;
                        d_cnt_s   = 9'd0;
                        d_cmp_s   = 1'b1;
                        if (d_rd_r) begin
                            d_dout_s = mem_r[d_addr_r];
                        end else begin
                            d_we_s = 1'b1;
                        end
                    end else begin
                        d_cnt_s = d_cnt_r - 9'd1;
                    end
                end
                ST_DONE: d_cmp_s = 1'b1;
                default: d_state_s = ST_IDLE;
            endcase
        end
    end

    // Data FSM registers and outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_state_r <= ST_IDLE;
            d_cnt_r   <= 9'd0;
            d_addr_r  <= '0;
            d_rd_r    <= 1'b0;
            d_din_r   <= 16'h0000;
            d_dout_r  <= 16'h0000;
            d_cmp_r   <= 1'b0;
        end else begin
            d_state_r <= d_state_s;
            d_cnt_r   <= d_cnt_s;
            d_addr_r  <= d_addr_s;
            d_rd_r    <= d_rd_s;
            d_din_r   <= d_din_s;
            d_dout_r  <= d_dout_s;
            d_cmp_r   <= d_cmp_s;
        end
    end

    // Memory array, never reset; the preload write is last so it wins a same-address clash.
    always_ff @(posedge clock) begin
        if (d_we_s && !reset) begin
            mem_r[d_waddr_s] <= d_wdata_s;
        end
        if (load_en) begin
            mem_r[la_s] <= load_data;
        end
    end

    assign Instr_dout     = i_dout_r;
    assign complete_instr = i_cmp_r;
    assign Data_dout      = d_dout_r;
    assign complete_data  = d_cmp_r;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: stimulus pushes expected responses, monitors pop
// and compare on each rising completion. Two instances cover INSTR_LAT=1 and INSTR_LAT=4.
module tb_lc3_mem_responder;

`ifdef LC3_MEM_RAND_STALL_EN
    localparam int EXTRA = 7;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        logic [15:0] data;
        int          issue;
        int          lo;
        int          hi;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = 16'h0000;
    logic [15:0] load_data = 16'h0000;

    logic        a_rd = 1'b0, a_dreq = 1'b0, a_drd = 1'b0;
    logic [15:0] a_pc = 16'h0000, a_daddr = 16'h0000, a_ddin = 16'h0000;
    logic [15:0] a_idout, a_ddout;
    logic        a_ci, a_cd;

    logic        b_rd = 1'b0;
    logic [15:0] b_pc = 16'h0000;
    logic [15:0] b_idout, b_ddout;
    logic        b_ci, b_cd;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0000;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] last_dout = 16'h0000;
    exp_t iq_a[$];
    exp_t iq_b[$];
    exp_t dq_a[$];
    logic a_ci_prev = 1'b0, b_ci_prev = 1'b0, a_cd_prev = 1'b0;

    lc3_mem_responder #(.AW(16), .INSTR_LAT(1), .DATA_LAT(2)) u_dut_a (
        .clock(clock), .reset(reset),
        .instrmem_rd(a_rd), .pc(a_pc), .Instr_dout(a_idout), .complete_instr(a_ci),
        .data_req(a_dreq), .Data_rd(a_drd), .Data_addr(a_daddr), .Data_din(a_ddin),
        .Data_dout(a_ddout), .complete_data(a_cd),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    lc3_mem_responder #(.AW(16), .INSTR_LAT(4), .DATA_LAT(2)) u_dut_b (
        .clock(clock), .reset(reset),
        .instrmem_rd(b_rd), .pc(b_pc), .Instr_dout(b_idout), .complete_instr(b_ci),
        .data_req(zero1), .Data_rd(zero1), .Data_addr(zero16), .Data_din(zero16),
        .Data_dout(b_ddout), .complete_data(b_cd),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_lat(input string name, input int lat, input int lo, input int hi);
        total = total + 1;
        if (lat < lo || lat > hi) begin
            bad = bad + 1;
            $display("FAIL %s: latency %0d expected %0d..%0d (cycle %0d)", name, lat, lo, hi, cyc);
        end
    endtask

    // Monitors: one pop per rising completion edge.
    always @(negedge clock) begin
        exp_t e;
        if (a_ci && !a_ci_prev) begin
            if (iq_a.size() == 0) begin
                check("a_instr_spurious", 32'(a_ci), 32'h0);
            end else begin
                e = iq_a.pop_front();
                check("a_instr_data", 32'(a_idout), 32'(e.data));
                check_lat("a_instr_lat", cyc - e.issue, e.lo, e.hi);
            end
        end
        if (b_ci && !b_ci_prev) begin
            if (iq_b.size() == 0) begin
                check("b_instr_spurious", 32'(b_ci), 32'h0);
            end else begin
                e = iq_b.pop_front();
                check("b_instr_data", 32'(b_idout), 32'(e.data));
                check_lat("b_instr_lat", cyc - e.issue, e.lo, e.hi);
            end
        end
        if (a_cd && !a_cd_prev) begin
            if (dq_a.size() == 0) begin
                check("a_data_spurious", 32'(a_cd), 32'h0);
            end else begin
                e = dq_a.pop_front();
                check("a_data_dout", 32'(a_ddout), 32'(e.data));
                check_lat("a_data_lat", cyc - e.issue, e.lo, e.hi);
            end
        end
        a_ci_prev = a_ci;
        b_ci_prev = b_ci;
        a_cd_prev = a_cd;
    end

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (iq_a.size() == 0 && iq_b.size() == 0 && dq_a.size() == 0) break;
            @(negedge clock);
        end
        if (iq_a.size() != 0 || iq_b.size() != 0 || dq_a.size() != 0) begin
            check("drain_timeout", 32'(iq_a.size() + iq_b.size() + dq_a.size()), 32'h0);
            iq_a.delete();
            iq_b.delete();
            dq_a.delete();
        end
    endtask

    task automatic load(input logic [15:0] addr, input logic [15:0] data);
        @(posedge clock); #1;
        load_en = 1'b1; load_addr = addr; load_data = data;
        @(posedge clock); #1;
        load_en = 1'b0;
    endtask

    task automatic fetch_a(input logic [15:0] addr, input logic [15:0] exp, input int hold);
        @(posedge clock); #1;
        a_rd = 1'b1; a_pc = addr;
        iq_a.push_back('{data: exp, issue: cyc, lo: 1, hi: 1 + EXTRA});
        drain();
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check("a_instr_hold", 32'(a_ci), 32'h1);
            check("a_instr_hold_data", 32'(a_idout), 32'(exp));
        end
        @(posedge clock); #1;
        a_rd = 1'b0;
        @(posedge clock); #1;
        check("a_instr_drop", 32'(a_ci), 32'h0);
    endtask

    task automatic data_a(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                          input logic [15:0] exp);
        @(posedge clock); #1;
        a_dreq = 1'b1; a_drd = rd; a_daddr = addr; a_ddin = din;
        dq_a.push_back('{data: exp, issue: cyc, lo: 2, hi: 2 + EXTRA});
        drain();
        @(posedge clock); #1;
        a_dreq = 1'b0;
        @(posedge clock); #1;
        check("a_data_drop", 32'(a_cd), 32'h0);
        last_dout = exp;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_a_idout", 32'(a_idout), 32'h0);
        check("rst_a_ci", 32'(a_ci), 32'h0);
        check("rst_a_ddout", 32'(a_ddout), 32'h0);
        check("rst_a_cd", 32'(a_cd), 32'h0);
        check("rst_b_ci", 32'(b_ci), 32'h0);
        reset = 1'b0;

        load(16'h3000, 16'h1021);
        load(16'h3001, 16'h2222);
        load(16'h3002, 16'h0A0A);
        load(16'h5000, 16'h0001);

        // Basic fetch, held for several cycles.
        fetch_a(16'h3000, 16'h1021, 3);
        fetch_a(16'h3001, 16'h2222, 0);

        // Write then read back.
        data_a(1'b0, 16'h4000, 16'hBEEF, 16'h0000);
        data_a(1'b1, 16'h4000, 16'hBEEF, 16'hBEEF);

        // pc change on the second wait cycle of a 4-cycle fetch restarts it.
        @(posedge clock); #1;
        b_rd = 1'b1; b_pc = 16'h3000;
        repeat (2) @(posedge clock);
        #1;
        b_pc = 16'h3001;
        iq_b.push_back('{data: 16'h2222, issue: cyc, lo: 4, hi: 4 + EXTRA});
        drain();
        @(posedge clock); #1;
        check("b_instr_hold", 32'(b_ci), 32'h1);
        b_rd = 1'b0;
        @(posedge clock); #1;
        check("b_instr_drop", 32'(b_ci), 32'h0);

        // Reset during a pending write aborts it.
        @(posedge clock); #1;
        a_dreq = 1'b1; a_drd = 1'b0; a_daddr = 16'h5000; a_ddin = 16'h9999;
        @(posedge clock); #1;
        reset = 1'b1; a_dreq = 1'b0;
        #1;
        check("rst_mid_ddout", 32'(a_ddout), 32'h0);
        check("rst_mid_cd", 32'(a_cd), 32'h0);
        check("rst_mid_idout", 32'(a_idout), 32'h0);
        check("rst_mid_b_idout", 32'(b_idout), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        last_dout = 16'h0000;
        data_a(1'b1, 16'h5000, 16'h0000, 16'h0001);

`ifndef LC3_MEM_RAND_STALL_EN
        // Write and fetch of one address completing together: fetch sees the old word.
        @(posedge clock); #1;
        a_dreq = 1'b1; a_drd = 1'b0; a_daddr = 16'h3002; a_ddin = 16'h1234;
        dq_a.push_back('{data: last_dout, issue: cyc, lo: 2, hi: 2});
        @(posedge clock); #1;
        a_rd = 1'b1; a_pc = 16'h3002;
        iq_a.push_back('{data: 16'h0A0A, issue: cyc, lo: 1, hi: 1});
        drain();
        @(posedge clock); #1;
        a_dreq = 1'b0; a_rd = 1'b0;
        @(posedge clock); #1;
        fetch_a(16'h3002, 16'h1234, 0);

        // Preload and data write to one address on the same edge: preload wins.
        @(posedge clock); #1;
        a_dreq = 1'b1; a_drd = 1'b0; a_daddr = 16'h3003; a_ddin = 16'h1111;
        dq_a.push_back('{data: last_dout, issue: cyc, lo: 2, hi: 2});
        @(posedge clock); #1;
        load_en = 1'b1; load_addr = 16'h3003; load_data = 16'h2222;
        @(posedge clock); #1;
        load_en = 1'b0;
        drain();
        @(posedge clock); #1;
        a_dreq = 1'b0;
        @(posedge clock); #1;
        data_a(1'b1, 16'h3003, 16'h0000, 16'h2222);
`else
        // Random stalls: every fetch latency bounded, data correct.
        for (int i = 0; i < 64; i++) begin
            load(16'h6000 + 16'(i), (16'h6000 + 16'(i)) ^ 16'h5A5A);
        end
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ad;
            ad = 16'h6000 + 16'((i * 7) % 64);
            fetch_a(ad, ad ^ 16'h5A5A, 0);
        end
`endif

        // Wrap: top address is an ordinary word.
        load(16'hFFFF, 16'hA5C3);
        fetch_a(16'hFFFF, 16'hA5C3, 1);

        check("b_cd_idle", 32'(b_cd), 32'h0);
        check("b_ddout_idle", 32'(b_ddout), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC3 core's instruction and data interfaces.
- Answers pc/instrmem_rd fetches with Instr_dout/complete_instr, and Data_addr/Data_rd/Data_din accesses with Data_dout/complete_data, after a programmable latency.
- Holds a unified word-addressed memory that the testbench preloads through a load port.
- Sits opposite the core in top-level benches and replaces the behavioural driver-side memory.

Parameters:
- AW, 16, address width; memory depth is 2**AW 16-bit words.
- INSTR_LAT, 1, cycles from accepted fetch to complete_instr (legal range 1..255).
- DATA_LAT, 2, cycles from accepted data request to complete_data (legal range 1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instrmem_rd  in  1  fetch request from the core.
- pc  in  16  fetch address; only the low AW bits are used.
- Instr_dout  out  16  fetched instruction word.
- complete_instr  out  1  fetch data valid.
- data_req  in  1  data access request (top derives it from the core's memory state).
- Data_rd  in  1  1 = read, 0 = write; sampled at acceptance.
- Data_addr  in  16  data address; only the low AW bits are used.
- Data_din  in  16  write data, sampled at acceptance.
- Data_dout  out  16  read data.
- complete_data  out  1  data access done.
- load_en  in  1  preload write strobe.
- load_addr  in  16  preload address.
- load_data  in  16  preload data.

Behaviour:
- Reset (async, active-high): both FSMs to IDLE; Instr_dout=0, complete_instr=0, Data_dout=0, complete_data=0; latency counters cleared. Memory contents are NOT cleared. Reset mid-wait aborts the access; a pending write is never performed.
- Instruction FSM, states IDLE -> WAIT -> DONE:
  - IDLE: instrmem_rd=1 latches pc into fetch_addr, loads cnt=INSTR_LAT-1, goes to WAIT (or to DONE if INSTR_LAT=1).
  - WAIT: decrements cnt; at 0 registers Instr_dout=mem[fetch_addr] and goes to DONE. complete_instr therefore rises exactly INSTR_LAT cycles after acceptance.
  - DONE: complete_instr=1 and Instr_dout held while instrmem_rd=1 and pc==fetch_addr (stall-safe hold).
  - pc change while in WAIT or DONE: restart, i.e. latch the new pc, reload cnt, complete_instr=0 next cycle.
  - instrmem_rd=0 in any state: go to IDLE; complete_instr=0 next cycle; Instr_dout keeps its last value.
- Data FSM, states IDLE -> WAIT -> DONE:
  - Identical timing with DATA_LAT; Data_addr, Data_rd and Data_din are latched at acceptance.
  - Read: Data_dout=mem[addr] registered on the WAIT->DONE edge.
  - Write: mem[addr]<=din performed exactly once, on the WAIT->DONE edge; Data_dout is unchanged.
  - DONE holds complete_data=1 while data_req=1 and Data_addr/Data_rd are unchanged.
  - Address or direction change while in WAIT or DONE: restart. data_req=0: return to IDLE.
- Same-cycle collisions:
  - Data write and fetch read of the same address completing together: the fetch returns the old word (read-before-write).
  - load_en and a data write to the same address in the same cycle: load_data wins.
  - load_en is otherwise independent of both FSMs and takes effect on the next clock edge.
- Address wrap: address bits above AW are ignored, so 16'hFFFF+1 naturally maps to 0. No overflow flag.
- The two FSMs are fully independent; simultaneous fetch and data accesses each see their own latency.

Optional Feature:
- LC3_MEM_RAND_STALL_EN:
  - Defined: a 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances every cycle. At each acceptance, LFSR[2:0] is added to the instruction latency and LFSR[5:3] to the data latency, giving 0..7 extra WAIT cycles. Hold, restart and collision rules are unchanged.
  - Undefined: no LFSR is present, and latency is exactly INSTR_LAT/DATA_LAT.

Test Plan:
- Preload mem[16'h3000]=16'h1021, INSTR_LAT=1; instrmem_rd=1, pc=16'h3000 -> complete_instr=1 one cycle later with Instr_dout=16'h1021, held while the request is held.
- DATA_LAT=2; write Data_addr=16'h4000, Data_din=16'hBEEF, then read 16'h4000 -> complete_data after 2 cycles for each; read returns Data_dout=16'hBEEF.
- INSTR_LAT=4; change pc from 16'h3000 to 16'h3001 on wait cycle 2 -> no complete_instr for the first address; complete_instr 4 cycles after the change, with mem[16'h3001].
- Assert reset during a pending write to 16'h5000 (old value 16'h0001) -> all outputs 0 immediately; mem[16'h5000] still 16'h0001 after reset.
- Data write 16'h1234 to 16'h3002 and fetch of 16'h3002 completing in the same cycle -> fetch returns the old word; a subsequent fetch returns 16'h1234.
- With LC3_MEM_RAND_STALL_EN defined, run 1000 fetches -> every fetch latency lies within INSTR_LAT..INSTR_LAT+7 and all returned data is correct.
